// File: rtl/sram_edac_responder.sv
// ============================================================================
// sram_edac_responder : SEC-DED protected on-chip SRAM target with burst support
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_edac_responder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sram_we_n,
  input  logic              sram_oe_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        wdata,
  input  logic              burst_mode,
  input  logic [15:0]       burst_length,
  input  logic              inj_en,
  input  logic [12:0]       inj_mask,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BURST_WR, BURST_RD} state_t;

  // Bit i of the vector holds Hamming position i+1; bit 12 is overall parity.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    c      = '0;
    c[2]   = d[0];
    c[4]   = d[1];
    c[5]   = d[2];
    c[6]   = d[3];
    c[8]   = d[4];
    c[9]   = d[5];
    c[10]  = d[6];
    c[11]  = d[7];
    c[0]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]   = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]   = d[4] ^ d[5] ^ d[6] ^ d[7];
    c[12]  = ^c[11:0];
    return c;
  endfunction

  logic [12:0]       mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       remain_q, remain_d;
  logic              busy_q, busy_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_corr_q, err_corr_d;
  logic              err_uncorr_q, err_uncorr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] beat_addr;
  logic [15:0]       first_remain;
  logic [12:0]       rd_word, fixed_word;
  logic [3:0]        syn;
  logic              par_fail, dec_corr, dec_uncorr;
  logic [7:0]        dec_data;

  assign first_remain = (burst_length == 16'd0) ? 16'd0 : burst_length - 16'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    beat_addr = addr_q;
    case (state_q)
      IDLE: begin
        beat_addr = sram_addr;
        if (!cs_n && (!sram_we_n || !sram_oe_n)) begin
          wr_en = !sram_we_n;
          rd_en = sram_we_n;
          if (burst_mode && first_remain != 16'd0) begin
            state_d  = !sram_we_n ? BURST_WR : BURST_RD;
            addr_d   = sram_addr + 1'b1;
            remain_d = first_remain;
            busy_d   = 1'b1;
          end
        end
      end
      default: begin
        if (cs_n) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en    = (state_q == BURST_WR);
          rd_en    = (state_q == BURST_RD);
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
    // Gate so that no array write happens while reset is asserted.
    wr_en = wr_en && rst_n;
  end

  always_comb begin
    rd_word    = mem_q[beat_addr];
    syn        = '0;
    for (int i = 1; i <= 12; i++) begin
      if (rd_word[i-1]) syn = syn ^ 4'(i);
    end
    par_fail   = ^rd_word;
    fixed_word = rd_word;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    if (par_fail) begin
      if (syn == 4'd0) begin
        dec_corr = 1'b1;
      end else if (syn <= 4'd12) begin
        fixed_word[syn - 4'd1] = ~rd_word[syn - 4'd1];
        dec_corr = 1'b1;
      end else begin
        dec_uncorr = 1'b1;
      end
    end else if (syn != 4'd0) begin
      dec_uncorr = 1'b1;
    end
    dec_data = {fixed_word[11], fixed_word[10], fixed_word[9], fixed_word[8],
                fixed_word[6], fixed_word[5], fixed_word[4], fixed_word[2]};
  end

  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = rd_en;
    err_corr_d    = rd_en && dec_corr;
    err_uncorr_d  = rd_en && dec_uncorr;
    err_addr_d    = err_addr_q;
    corr_cnt_d    = corr_cnt_q;
    uncorr_cnt_d  = uncorr_cnt_q;
    if (rd_en) rdata_d = dec_data;
    if (err_corr_d || err_uncorr_d) err_addr_d = beat_addr;
    if (err_corr_d && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + 1'b1;
    if (err_uncorr_d && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[beat_addr] <= encode(wdata) ^ (inj_en ? inj_mask : 13'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      busy_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_corr_q    <= 1'b0;
      err_uncorr_q  <= 1'b0;
      err_addr_q    <= '0;
      corr_cnt_q    <= '0;
      uncorr_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_corr_q    <= err_corr_d;
      err_uncorr_q  <= err_uncorr_d;
      err_addr_q    <= err_addr_d;
      corr_cnt_q    <= corr_cnt_d;
      uncorr_cnt_q  <= uncorr_cnt_d;
    end
  end

  assign rdata             = rdata_q;
  assign rdata_valid       = rdata_valid_q;
  assign busy              = busy_q;
  assign err_corrected     = err_corr_q;
  assign err_uncorrectable = err_uncorr_q;
  assign err_addr          = err_addr_q;
  assign corr_count        = corr_cnt_q;
  assign uncorr_count      = uncorr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_edac_responder.sv
// ============================================================================
// tb_sram_edac_responder : directed bench for sram_edac_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_edac_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, sram_we_n, sram_oe_n;
  logic [7:0]  sram_addr;
  logic [7:0]  wdata;
  logic        burst_mode;
  logic [15:0] burst_length;
  logic        inj_en;
  logic [12:0] inj_mask;
  logic [7:0]  rdata;
  logic        rdata_valid, busy, err_corrected, err_uncorrectable;
  logic [7:0]  err_addr, corr_count, uncorr_count;

  int tests = 0;
  int fails = 0;

  sram_edac_responder #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cs_n              (cs_n),
    .sram_we_n         (sram_we_n),
    .sram_oe_n         (sram_oe_n),
    .sram_addr         (sram_addr),
    .wdata             (wdata),
    .burst_mode        (burst_mode),
    .burst_length      (burst_length),
    .inj_en            (inj_en),
    .inj_mask          (inj_mask),
    .rdata             (rdata),
    .rdata_valid       (rdata_valid),
    .busy              (busy),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .err_addr          (err_addr),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic cs, input logic we, input logic oe, input logic [7:0] a,
                     input logic [7:0] d, input logic bm, input logic [15:0] bl,
                     input logic ie, input logic [12:0] im);
    cs_n = cs; sram_we_n = we; sram_oe_n = oe; sram_addr = a; wdata = d;
    burst_mode = bm; burst_length = bl; inj_en = ie; inj_mask = im;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] d, input logic ie, input logic [12:0] im);
    drv(1'b0, 1'b0, 1'b1, a, d, 1'b0, 16'd1, ie, im);
    tick();
  endtask

  task automatic rd1(input logic [7:0] a);
    drv(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0, 16'd1, 1'b0, 13'h0);
    tick();
  endtask

  task automatic idle();
    drv(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 16'd0, 1'b0, 13'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick(); tick();
    chk("rst_rdata", 16'(rdata), 16'h00);
    chk("rst_valid", 16'(rdata_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err_addr", 16'(err_addr), 16'h00);
    chk("rst_counts", {corr_count, uncorr_count}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Single writes and reads with one-cycle latency
    wr1(8'h01, 8'hAA, 1'b0, 13'h0);
    wr1(8'h02, 8'hBB, 1'b0, 13'h0);
    rd1(8'h01);
    chk("rd01_valid", 16'(rdata_valid), 16'h1);
    chk("rd01_data", 16'(rdata), 16'hAA);
    chk("rd01_flags", {14'h0, err_corrected, err_uncorrectable}, 16'h0);
    rd1(8'h02);
    chk("rd02_valid", 16'(rdata_valid), 16'h1);
    chk("rd02_data", 16'(rdata), 16'hBB);
    idle(); tick();
    chk("valid_pulse", 16'(rdata_valid), 16'h0);

    // Burst write FE..01 wrapping
    drv(1'b0, 1'b0, 1'b1, 8'hFE, 8'hCC, 1'b1, 16'd4, 1'b0, 13'h0); tick();
    chk("bw_busy1", 16'(busy), 16'h1);
    wdata = 8'hDD; sram_addr = 8'h55; tick();
    chk("bw_busy2", 16'(busy), 16'h1);
    wdata = 8'hEE; tick();
    chk("bw_busy3", 16'(busy), 16'h1);
    wdata = 8'hFF; tick();
    chk("bw_busy_end", 16'(busy), 16'h0);

    drv(1'b0, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b1, 16'd4, 1'b0, 13'h0); tick();
    chk("br0", {7'h0, rdata_valid, rdata}, 16'h1CC);
    chk("br_busy", 16'(busy), 16'h1);
    tick();
    chk("br1", {7'h0, rdata_valid, rdata}, 16'h1DD);
    tick();
    chk("br2", {7'h0, rdata_valid, rdata}, 16'h1EE);
    tick();
    chk("br3", {7'h0, rdata_valid, rdata}, 16'h1FF);
    chk("br_busy_end", 16'(busy), 16'h0);
    idle(); tick();
    chk("br_done_valid", 16'(rdata_valid), 16'h0);
    rd1(8'h00);
    chk("wrap_addr00", 16'(rdata), 16'hEE);

    // Single-bit error on d0
    wr1(8'h10, 8'h5A, 1'b1, 13'h004);
    rd1(8'h10);
    chk("sec_data", 16'(rdata), 16'h5A);
    chk("sec_flags", {14'h0, err_corrected, err_uncorrectable}, 16'h2);
    chk("sec_err_addr", 16'(err_addr), 16'h10);
    chk("sec_corr_count", 16'(corr_count), 16'h01);
    idle(); tick();
    chk("sec_pulse", 16'(err_corrected), 16'h0);

    // Double-bit error (positions 2,3): raw data returned, d0 flipped
    wr1(8'h11, 8'h5A, 1'b1, 13'h006);
    rd1(8'h11);
    chk("ded_flags", {14'h0, err_corrected, err_uncorrectable}, 16'h1);
    chk("ded_data", 16'(rdata), 16'h5B);
    chk("ded_counts", {corr_count, uncorr_count}, 16'h0101);
    chk("ded_err_addr", 16'(err_addr), 16'h11);

    // Overall-parity bit error: data good, corrected
    wr1(8'h12, 8'h3C, 1'b1, 13'h1000);
    rd1(8'h12);
    chk("p13_data", 16'(rdata), 16'h3C);
    chk("p13_flags", {14'h0, err_corrected, err_uncorrectable}, 16'h2);
    chk("p13_corr_count", 16'(corr_count), 16'h02);

    // burst_length 0 behaves as one beat
    drv(1'b0, 1'b0, 1'b1, 8'h20, 8'h77, 1'b1, 16'd0, 1'b0, 13'h0); tick();
    chk("bl0_busy", 16'(busy), 16'h0);
    wr1(8'h21, 8'h88, 1'b0, 13'h0);
    rd1(8'h20);
    chk("bl0_rd20", 16'(rdata), 16'h77);
    rd1(8'h21);
    chk("bl0_rd21", 16'(rdata), 16'h88);

    // cs_n abort after two beats of a length-8 burst write
    wr1(8'h32, 8'h11, 1'b0, 13'h0);
    drv(1'b0, 1'b0, 1'b1, 8'h30, 8'hA0, 1'b1, 16'd8, 1'b0, 13'h0); tick();
    wdata = 8'hA1; tick();
    idle(); wdata = 8'hA2; tick();
    chk("abort_busy", 16'(busy), 16'h0);
    rd1(8'h30);
    chk("abort_rd30", 16'(rdata), 16'hA0);
    rd1(8'h31);
    chk("abort_rd31", 16'(rdata), 16'hA1);
    rd1(8'h32);
    chk("abort_rd32", 16'(rdata), 16'h11);

    // Reset mid burst read
    drv(1'b0, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b1, 16'd4, 1'b0, 13'h0); tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {7'h0, rdata_valid, rdata}, 16'h000);
    chk("mid_rst_busy_flags", {13'h0, busy, err_corrected, err_uncorrectable}, 16'h0);
    chk("mid_rst_counts", {corr_count, uncorr_count}, 16'h0000);
    chk("mid_rst_err_addr", 16'(err_addr), 16'h00);
    idle(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 16'(rdata_valid), 16'h0);

    // Counter saturation with repeated corrected reads of 0x10
    for (int i = 0; i < 254; i++) rd1(8'h10);
    chk("sat_fe", 16'(corr_count), 16'hFE);
    for (int i = 0; i < 10; i++) rd1(8'h10);
    chk("sat_ff", 16'(corr_count), 16'hFF);
    chk("sat_flag", 16'(err_corrected), 16'h1);
    chk("sat_uncorr", 16'(uncorr_count), 16'h00);
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
